// File: rtl/la_vdemux5_reg.sv
// rtl/la_vdemux5_reg.sv - registered 5-output one-hot vector demux with per-channel holding registers
// Optional feature macro: LA_VDEMUX5_DROPCNT_EN (saturating zero-hot drop counter on drops)
module la_vdemux5_reg #(
  parameter int N    = 1,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sel4,
  input  logic         sel3,
  input  logic         sel2,
  input  logic         sel1,
  input  logic         sel0,
  input  logic [N-1:0] in,
  output logic         valid4,
  output logic         valid3,
  output logic         valid2,
  output logic         valid1,
  output logic         valid0,
  input  logic         ready4,
  input  logic         ready3,
  input  logic         ready2,
  input  logic         ready1,
  input  logic         ready0,
  output logic [N-1:0] out4,
  output logic [N-1:0] out3,
  output logic [N-1:0] out2,
  output logic [N-1:0] out1,
  output logic [N-1:0] out0,
  output logic [7:0]   drops
);

  logic [4:0]   w_sel;
  logic [4:0]   w_ready;
  logic [4:0]   w_free;
  logic         w_xfer;
  logic         w_drop;
  logic         w_prop_unused;
  logic [4:0]   r_valid;
  logic [N-1:0] r_out [5];

  // PROP is a pass-through cell property with no effect on the logic
  assign w_prop_unused = |PROP;

  assign w_sel   = {sel4, sel3, sel2, sel1, sel0};
  assign w_ready = {ready4, ready3, ready2, ready1, ready0};

  // A channel can take a word when it is empty or being drained this cycle;
  // the input is accepted only if every selected channel can take it, so a
  // broadcast is all-or-nothing and zero-hot always accepts.
  assign w_free   = ~r_valid | w_ready;
  assign in_ready = &(~w_sel | w_free);
  assign w_xfer   = in_valid & in_ready;
  assign w_drop   = in_valid & (w_sel == 5'b0);

  genvar k;
  generate
    for (k = 0; k < 5; k++) begin : g_ch
      // Per-channel holding register: refill wins over drain, data kept after drain
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid[k] <= 1'b0;
          r_out[k]   <= '0;
        end else if (w_xfer && w_sel[k]) begin
          r_valid[k] <= 1'b1;
          r_out[k]   <= in;
        end else if (r_valid[k] && w_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  endgenerate

  assign {valid4, valid3, valid2, valid1, valid0} = r_valid;
  assign out4 = r_out[4];
  assign out3 = r_out[3];
  assign out2 = r_out[2];
  assign out1 = r_out[1];
  assign out0 = r_out[0];

`ifdef LA_VDEMUX5_DROPCNT_EN
  logic [7:0] r_drops;

  // Count zero-hot transfers, saturating at 255 until the next reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drops <= 8'd0;
    end else if (w_drop && (r_drops != 8'hFF)) begin
      r_drops <= r_drops + 8'd1;
    end
  end

  assign drops = r_drops;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
  assign drops = 8'd0;
`endif

endmodule
